// File: rtl/keypad_code_checker.sv
// Keypad access-code checker: feeds entered/stored digit pairs to an external
// subtractor, accumulates per-digit matches and drives unlock, lockout and alarm.
module keypad_code_checker #(
  parameter int          DIGITS        = 4,
  parameter logic [31:0] CODE          = 32'h0000_1234,
  parameter int          MAX_TRIES     = 3,
  parameter int          UNLOCK_CYCLES = 500,
  parameter int          LOCK_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_i,
  input  logic       digit_valid_i,
  input  logic       clear_i,
  output logic [3:0] sub_a_o,
  output logic [3:0] sub_b_o,
  input  logic [3:0] sub_diff_i,
  input  logic       sub_cout_i,
  output logic       unlock_o,
  output logic       locked_o,
  output logic       alarm_o,
  output logic       busy_o,
  output logic [1:0] attempts_o,
  output logic [2:0] digit_count_o
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {ENTRY, COMPARE, VERDICT, OPEN, LOCKED} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic          mismatch;
  logic [1:0]    tries;
  logic [TW-1:0] timer;
  logic [3:0]    code_digit;
  logic          digit_match;

  // A-B of equal operands yields zero with carry-out set; anything else is a miss.
  assign digit_match = (sub_diff_i == 4'h0) && sub_cout_i;
  assign attempts_o  = tries;

  always_comb begin
    code_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) code_digit = CODE[4*(DIGITS-1-i) +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ENTRY;
      idx           <= 4'd0;
      mismatch      <= 1'b0;
      tries         <= 2'd0;
      timer         <= '0;
      sub_a_o       <= 4'h0;
      sub_b_o       <= 4'h0;
      unlock_o      <= 1'b0;
      locked_o      <= 1'b0;
      alarm_o       <= 1'b0;
      busy_o        <= 1'b0;
      digit_count_o <= 3'd0;
    end else begin
      alarm_o <= 1'b0;
      case (state)
        ENTRY: begin
          if (clear_i) begin
            idx           <= 4'd0;
            mismatch      <= 1'b0;
            digit_count_o <= 3'd0;
          end else if (digit_valid_i) begin
            sub_a_o <= digit_i;
            sub_b_o <= code_digit;
            busy_o  <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          mismatch      <= mismatch | ~digit_match;
          idx           <= idx + 4'd1;
          digit_count_o <= 3'(idx + 4'd1);
          if (int'(idx) + 1 == DIGITS) begin
            state <= VERDICT;
          end else begin
            busy_o <= 1'b0;
            state  <= ENTRY;
          end
        end
        VERDICT: begin
          idx           <= 4'd0;
          mismatch      <= 1'b0;
          digit_count_o <= 3'd0;
          busy_o        <= 1'b0;
          if (!mismatch) begin
            tries    <= 2'd0;
            timer    <= TW'(UNLOCK_CYCLES - 1);
            unlock_o <= 1'b1;
            state    <= OPEN;
          end else if (int'(tries) + 1 == MAX_TRIES) begin
            tries    <= 2'd0;
            timer    <= TW'(LOCK_CYCLES - 1);
            alarm_o  <= 1'b1;
            locked_o <= 1'b1;
            state    <= LOCKED;
          end else begin
            tries <= tries + 2'd1;
            state <= ENTRY;
          end
        end
        OPEN: begin
          if (clear_i || timer == '0) begin
            timer    <= '0;
            unlock_o <= 1'b0;
            state    <= ENTRY;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCKED: begin
          if (timer == '0) begin
            locked_o <= 1'b0;
            state    <= ENTRY;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule
